// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM states, default width,
// counter width and the most-negative operand value.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH);
  localparam logic [DIV_WIDTH-1:0] DIV_INT_MIN = {1'b1, {(DIV_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_FIX,
    ST_DONE
  } div_state_e;

endpackage

// File: rtl/div_32_seq_if.sv
// Start/operand/result bundle for div_32_seq. data_remainder exists only when
// DIV_REMAINDER_OUT_EN is defined.
interface div_32_seq_if
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
);

  logic             ctrl_div;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
`ifdef DIV_REMAINDER_OUT_EN
  logic [WIDTH-1:0] data_remainder;

  modport master (
    output ctrl_div, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRDY, data_remainder
  );

  modport slave (
    input  ctrl_div, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY, data_remainder
  );
`else
  modport master (
    output ctrl_div, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRDY
  );

  modport slave (
    input  ctrl_div, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY
  );
`endif

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit and
// conditionally subtract the divisor using a WIDTH+1 bit subtract.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             dvd_bit_i,
  input  logic [WIDTH-1:0] dsr_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH-1:0] shifted;
  logic [WIDTH:0]   diff;

  always_comb begin
    shifted = {rem_i[WIDTH-2:0], dvd_bit_i};
    diff    = {1'b0, shifted} - {1'b0, dsr_i};
    // A set MSB shifted out of rem means the true partial remainder exceeds 2^WIDTH.
    q_o     = rem_i[WIDTH-1] | ~diff[WIDTH];
    rem_o   = q_o ? diff[WIDTH-1:0] : shifted;
  end

endmodule

// File: rtl/div_32_seq.sv
// Iterative restoring divider, one quotient bit per clock, signed or unsigned.
// Define DIV_REMAINDER_OUT_EN to expose the registered remainder.
module div_32_seq
  import div_pkg::*;
#(
  parameter int unsigned WIDTH  = DIV_WIDTH,
  parameter bit          SIGNED = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  div_32_seq_if.slave bus
);

  localparam int unsigned      CNT_W   = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic             exc_q, exc_d, rdy_q, rdy_d;
`ifdef DIV_REMAINDER_OUT_EN
  logic [WIDTH-1:0] rem_out_q, rem_out_d;
`endif

  logic [WIDTH-1:0] abs_a, abs_b, step_rem;
  logic             neg_a, neg_b, step_q;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .dvd_bit_i (dvd_q[WIDTH-1]),
    .dsr_i     (dsr_q),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    dvd_d    = dvd_q;
    rem_d    = rem_q;
    dsr_d    = dsr_q;
    result_d = result_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;
`ifdef DIV_REMAINDER_OUT_EN
    rem_out_d = rem_out_q;
`endif
    neg_a = SIGNED && bus.data_operandA[WIDTH-1];
    neg_b = SIGNED && bus.data_operandB[WIDTH-1];
    abs_a = neg_a ? ~bus.data_operandA + ONE : bus.data_operandA;
    abs_b = neg_b ? ~bus.data_operandB + ONE : bus.data_operandB;

    // A start in any state wins: it aborts whatever was in flight.
    if (bus.ctrl_div) begin
      if (bus.data_operandB == '0) begin
        result_d = '0;
        exc_d    = 1'b1;
        rdy_d    = 1'b1;
        state_d  = ST_DONE;
`ifdef DIV_REMAINDER_OUT_EN
        rem_out_d = bus.data_operandA;
`endif
      end else if (SIGNED && bus.data_operandA == INT_MIN && bus.data_operandB == '1) begin
        result_d = INT_MIN;
        exc_d    = 1'b1;
        rdy_d    = 1'b1;
        state_d  = ST_DONE;
`ifdef DIV_REMAINDER_OUT_EN
        rem_out_d = '0;
`endif
      end else begin
        dvd_d    = abs_a;
        dsr_d    = abs_b;
        rem_d    = '0;
        sign_a_d = neg_a;
        sign_b_d = neg_b;
        count_d  = '0;
        state_d  = ST_BUSY;
      end
    end else begin
      case (state_q)
        ST_BUSY: begin
          rem_d   = step_rem;
          dvd_d   = {dvd_q[WIDTH-2:0], step_q};
          count_d = count_q + CNT_ONE;
          if (count_q == LAST) state_d = ST_FIX;
        end
        ST_FIX: begin
          result_d = (sign_a_q ^ sign_b_q) ? ~dvd_q + ONE : dvd_q;
          exc_d    = 1'b0;
          rdy_d    = 1'b1;
          state_d  = ST_DONE;
`ifdef DIV_REMAINDER_OUT_EN
          rem_out_d = sign_a_q ? ~rem_q + ONE : rem_q;
`endif
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      dvd_q    <= '0;
      rem_q    <= '0;
      dsr_q    <= '0;
      result_q <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
`ifdef DIV_REMAINDER_OUT_EN
      rem_out_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      dvd_q    <= dvd_d;
      rem_q    <= rem_d;
      dsr_q    <= dsr_d;
      result_q <= result_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
`ifdef DIV_REMAINDER_OUT_EN
      rem_out_q <= rem_out_d;
`endif
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;
`ifdef DIV_REMAINDER_OUT_EN
  assign bus.data_remainder = rem_out_q;
`endif

endmodule

// File: tb/tb_div_32_seq.sv
// Bench for div_32_seq: signed and unsigned instances, fixed vectors,
// multi-cycle corner sequences and a random sweep against an arithmetic model.
module tb_div_32_seq;
  import div_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_32_seq_if #(.WIDTH(32)) sif ();
  div_32_seq_if #(.WIDTH(32)) uif ();

  div_32_seq #(.WIDTH(32), .SIGNED(1'b1)) u_dut_s (.clock(clk), .reset(rst), .bus(sif.slave));
  div_32_seq #(.WIDTH(32), .SIGNED(1'b0)) u_dut_u (.clock(clk), .reset(rst), .bus(uif.slave));

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    bit          u;
    logic [31:0] q;
    logic [31:0] r;
    logic        exc;
    int          lat;
  } vec_t;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] get_q(bit u);
    return u ? uif.data_result : sif.data_result;
  endfunction
  function automatic logic get_exc(bit u);
    return u ? uif.data_exception : sif.data_exception;
  endfunction
  function automatic logic get_rdy(bit u);
    return u ? uif.data_resultRDY : sif.data_resultRDY;
  endfunction
`ifdef DIV_REMAINDER_OUT_EN
  function automatic logic [31:0] get_r(bit u);
    return u ? uif.data_remainder : sif.data_remainder;
  endfunction
`endif

  // Reference: plain integer division semantics, independent of the iteration.
  function automatic vec_t model(logic [31:0] a, logic [31:0] b, bit u);
    vec_t   v;
    longint sa, sb;
    v.a = a; v.b = b; v.u = u; v.exc = 1'b0; v.lat = 34;
    if (b == 32'd0) begin
      v.q = 32'd0; v.r = a; v.exc = 1'b1; v.lat = 1;
    end else if (u) begin
      v.q = a / b; v.r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      v.q = 32'h8000_0000; v.r = 32'd0; v.exc = 1'b1; v.lat = 1;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      v.q = 32'(sa / sb);
      v.r = 32'(sa % sb);
    end
    return v;
  endfunction

  function automatic vec_t mk(logic [31:0] a, logic [31:0] b, bit u,
                              logic [31:0] q, logic [31:0] r, logic exc, int lat);
    vec_t v;
    v.a = a; v.b = b; v.u = u; v.q = q; v.r = r; v.exc = exc; v.lat = lat;
    return v;
  endfunction

  task automatic clear_ctrl();
    sif.ctrl_div = 1'b0;
    uif.ctrl_div = 1'b0;
  endtask

  // Called just after a rising edge; the start is sampled on the next edge.
  task automatic launch(input bit u, input logic [31:0] a, input logic [31:0] b);
    if (u) begin
      uif.data_operandA = a; uif.data_operandB = b; uif.ctrl_div = 1'b1;
    end else begin
      sif.data_operandA = a; sif.data_operandB = b; sif.ctrl_div = 1'b1;
    end
  endtask

  task automatic wait_rdy(input bit u, output int lat);
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      clear_ctrl();
      if (get_rdy(u)) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic check_result(input string tag, input vec_t e, input int lat);
    check({tag, ".lat"}, 32'(lat), 32'(e.lat));
    check({tag, ".q"}, get_q(e.u), e.q);
    check({tag, ".exc"}, {31'd0, get_exc(e.u)}, {31'd0, e.exc});
`ifdef DIV_REMAINDER_OUT_EN
    check({tag, ".rem"}, get_r(e.u), e.r);
`endif
  endtask

  task automatic run_vec(input string tag, input vec_t e);
    int lat;
    launch(e.u, e.a, e.b);
    wait_rdy(e.u, lat);
    check_result(tag, e, lat);
    @(posedge clk); #1;
    check({tag, ".rdy_pulse"}, {31'd0, get_rdy(e.u)}, 32'd0);
    check({tag, ".hold"}, get_q(e.u), e.q);
  endtask

  vec_t vecs[12];

  initial begin
    int   lat;
    bit   seen;
    vec_t e;
    logic [31:0] ra, rb;

    vecs[0]  = mk(32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0, 34);
    vecs[1]  = mk(32'hFFFF_FF9C,  32'd7,          1'b0, 32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0, 34);
    vecs[2]  = mk(32'd100,        32'hFFFF_FFF9,  1'b0, 32'hFFFF_FFF2,  32'd2,          1'b0, 34);
    vecs[3]  = mk(32'd45673475,   32'd0,          1'b0, 32'd0,          32'd45673475,   1'b1, 1);
    vecs[4]  = mk(32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'h8000_0000,  32'd0,          1'b1, 1);
    vecs[5]  = mk(32'd5,          32'd100,        1'b0, 32'd0,          32'd5,          1'b0, 34);
    vecs[6]  = mk(32'h8000_0000,  32'd1,          1'b0, 32'h8000_0000,  32'd0,          1'b0, 34);
    vecs[7]  = mk(32'h8000_0000,  32'd3,          1'b0, 32'hD555_5556,  32'hFFFF_FFFE,  1'b0, 34);
    vecs[8]  = mk(32'hFFFF_FFFF,  32'd2,          1'b1, 32'h7FFF_FFFF,  32'd1,          1'b0, 34);
    vecs[9]  = mk(32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, 32'd1,          32'd0,          1'b0, 34);
    vecs[10] = mk(32'hFFFF_FFFF,  32'h8000_0001,  1'b1, 32'd1,          32'h7FFF_FFFE,  1'b0, 34);
    vecs[11] = mk(32'd0,          32'd0,          1'b1, 32'd0,          32'd0,          1'b1, 1);

    rst = 1'b1;
    clear_ctrl();
    sif.data_operandA = '0; sif.data_operandB = '0;
    uif.data_operandA = '0; uif.data_operandB = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.q", get_q(1'b0), 32'd0);
    check("reset.exc", {31'd0, get_exc(1'b0)}, 32'd0);
    check("reset.rdy", {31'd0, get_rdy(1'b0)}, 32'd0);
    check("reset.q_u", get_q(1'b1), 32'd0);
`ifdef DIV_REMAINDER_OUT_EN
    check("reset.rem", get_r(1'b0), 32'd0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Restart 10 cycles into an op: only the second op may report.
    launch(1'b0, 32'd1000, 32'd3);
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      clear_ctrl();
      if (get_rdy(1'b0)) seen = 1'b1;
    end
    check("abort.early_rdy", {31'd0, seen}, 32'd0);
    launch(1'b0, 32'd9, 32'd2);
    wait_rdy(1'b0, lat);
    check_result("abort", mk(32'd9, 32'd2, 1'b0, 32'd4, 32'd1, 1'b0, 34), lat);

    // Start issued during the DONE cycle of the previous op.
    repeat (3) @(posedge clk);
    #1;
    launch(1'b0, 32'd100, 32'd7);
    wait_rdy(1'b0, lat);
    check_result("b2b_first", vecs[0], lat);
    launch(1'b0, 32'd1000, 32'd3);
    wait_rdy(1'b0, lat);
    check_result("b2b_second", mk(32'd1000, 32'd3, 1'b0, 32'd333, 32'd1, 1'b0, 34), lat);

    // Reset in the middle of an op.
    @(posedge clk); #1;
    launch(1'b0, 32'd1000, 32'd3);
    repeat (20) begin
      @(posedge clk); #1;
      clear_ctrl();
    end
    rst = 1'b1;
    @(negedge clk);
    check("midrst.q", get_q(1'b0), 32'd0);
    check("midrst.exc", {31'd0, get_exc(1'b0)}, 32'd0);
    check("midrst.rdy", {31'd0, get_rdy(1'b0)}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (get_rdy(1'b0)) seen = 1'b1;
    end
    check("midrst.no_rdy", {31'd0, seen}, 32'd0);
    run_vec("after_rst", vecs[0]);

    // Random sweep on both instances.
    for (int i = 0; i < 60; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 4))
        0: rb = $urandom;
        1: rb = $urandom_range(1, 255);
        2: rb = 32'd0 - 32'($urandom_range(1, 100));
        3: rb = $urandom >> $urandom_range(0, 31);
        default: rb = (i % 3 == 0) ? 32'd0 : 32'($urandom_range(1, 9));
      endcase
      if (i % 17 == 5) ra = DIV_INT_MIN;
      if (i % 19 == 7) rb = 32'hFFFF_FFFF;
      e = model(ra, rb, i[0]);
      launch(e.u, ra, rb);
      wait_rdy(e.u, lat);
      check_result($sformatf("rand%0d", i), e, lat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
